s_maq_seq: RTL

S_MAQ_SEQ -- requirements
Module: s_maq_seq

---
 rtl/s_maq_seq.sv | 193 +++++++++++++++++++
 1 files changed

// File: rtl/s_maq_seq.sv
`default_nettype none
// ============================================================================
// Module   : s_maq_seq
// Purpose  : Element sequencer for the S_MAQ cell-state datapath. Walks one
//            vector of VEC_LEN elements: accepts an element (f, c, i, g),
//            forms the forget-gate product f*c in temp_regA, pulses
//            comb_ctrl=3 for one cycle so the external datapath produces the
//            saturated new Ct, captures it, and presents it with its index
//            on a valid/ready output port.
// Ports    : clk, rst                - clock, synchronous active-high reset
//            start / busy / done     - pass control and status
//            in_valid / in_ready     - element input handshake
//            in_f, in_c, in_i, in_g  - forget gate, previous Ct, input gate,
//                                      candidate
//            comb_ctrl, temp_regA/B/C- drive to the S_MAQ datapath
//            S_sat_MAQ               - saturated Ct returned by the datapath
//            out_valid / out_ready   - result handshake
//            out_c / out_idx         - new Ct and its element index
//            sat_cnt                 - saturation count (only with macro)
// Options  : define S_MAQ_SEQ_SATCNT_EN to add the sat_cnt output, counting
//            captured results equal to 8'd0 or 8'd255 within a pass.
// Revision : 1.0 - initial release
// ============================================================================
module s_maq_seq #(
    parameter int         VEC_LEN          = 32,
    parameter logic [7:0] ZERO_STATE       = 8'd128,
    parameter logic [7:0] OUT_ZERO_SIGMOID = 8'd0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    output logic        busy,
    output logic        done,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [7:0]  in_f,
    input  logic [7:0]  in_c,
    input  logic [7:0]  in_i,
    input  logic [7:0]  in_g,
    output logic [4:0]  comb_ctrl,
    output logic [16:0] temp_regA,
    output logic [7:0]  temp_regB,
    output logic [7:0]  temp_regC,
    input  logic [7:0]  S_sat_MAQ,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [7:0]  out_c,
    output logic [9:0]  out_idx
`ifdef S_MAQ_SEQ_SATCNT_EN
    ,
    output logic [10:0] sat_cnt
`endif
);

    localparam logic [2:0] c_ST_IDLE = 3'd0;
    localparam logic [2:0] c_ST_LOAD = 3'd1;
    localparam logic [2:0] c_ST_MUL  = 3'd2;
    localparam logic [2:0] c_ST_MAQ  = 3'd3;
    localparam logic [2:0] c_ST_OUT  = 3'd4;
    localparam logic [2:0] c_ST_DONE = 3'd5;

    localparam logic [9:0] c_LAST_IDX = 10'(VEC_LEN - 1);
    localparam logic [4:0] c_CTRL_MAQ = 5'd3;

    logic [2:0]  r_state;
    logic        r_busy;
    logic        r_done;
    logic        r_in_ready;
    logic        r_out_valid;
    logic [4:0]  r_comb_ctrl;
    logic [7:0]  r_f;
    logic [7:0]  r_c;
    logic [16:0] r_temp_a;
    logic [7:0]  r_temp_b;
    logic [7:0]  r_temp_c;
    logic [7:0]  r_out_c;
    logic [9:0]  r_cnt;

    logic [2:0]  w_state_nxt;
    logic        w_accept;
    logic        w_out_hs;
    logic [8:0]  w_f_off;
    logic [8:0]  w_c_off;
    logic [16:0] w_prod;

    assign w_accept = r_in_ready & in_valid;
    assign w_out_hs = r_out_valid & out_ready;

    // Zero-point removal yields 9-bit two's complement operands; sign-extend
    // to 17 bits so the low 17 bits of an unsigned multiply are the exact
    // signed product (range -32640..32385 always fits).
    assign w_f_off = {1'b0, r_f} - {1'b0, OUT_ZERO_SIGMOID};
    assign w_c_off = {1'b0, r_c} - {1'b0, ZERO_STATE};
    assign w_prod  = {{8{w_f_off[8]}}, w_f_off} * {{8{w_c_off[8]}}, w_c_off};

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: if (start)    w_state_nxt = c_ST_LOAD;
            c_ST_LOAD: if (w_accept) w_state_nxt = c_ST_MUL;
            c_ST_MUL:                w_state_nxt = c_ST_MAQ;
            c_ST_MAQ:                w_state_nxt = c_ST_OUT;
            c_ST_OUT: begin
                if (w_out_hs) begin
                    w_state_nxt = (r_cnt == c_LAST_IDX) ? c_ST_DONE : c_ST_LOAD;
                end
            end
            c_ST_DONE:               w_state_nxt = c_ST_IDLE;
            default:                 w_state_nxt = c_ST_IDLE;
        endcase
    end

    // Status/handshake outputs are registered from the next state so each
    // one is a clean flop output aligned with the state it describes.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= c_ST_IDLE;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_in_ready  <= 1'b0;
            r_out_valid <= 1'b0;
            r_comb_ctrl <= 5'd0;
            r_f         <= 8'd0;
            r_c         <= 8'd0;
            r_temp_a    <= 17'd0;
            r_temp_b    <= 8'd0;
            r_temp_c    <= 8'd0;
            r_out_c     <= 8'd0;
            r_cnt       <= 10'd0;
        end else begin
            r_state     <= w_state_nxt;
            r_busy      <= (w_state_nxt == c_ST_LOAD) || (w_state_nxt == c_ST_MUL) ||
                           (w_state_nxt == c_ST_MAQ)  || (w_state_nxt == c_ST_OUT);
            r_done      <= (w_state_nxt == c_ST_DONE);
            r_in_ready  <= (w_state_nxt == c_ST_LOAD);
            r_out_valid <= (w_state_nxt == c_ST_OUT);
            r_comb_ctrl <= (w_state_nxt == c_ST_MAQ) ? c_CTRL_MAQ : 5'd0;

            if ((r_state == c_ST_IDLE) && start) begin
                r_cnt <= 10'd0;
            end
            if (w_accept) begin
                r_f      <= in_f;
                r_c      <= in_c;
                r_temp_b <= in_i;
                r_temp_c <= in_g;
            end
            if (r_state == c_ST_MUL) begin
                r_temp_a <= w_prod;
            end
            if (r_state == c_ST_MAQ) begin
                r_out_c <= S_sat_MAQ;
            end
            // Wraps to zero after index 1023 when VEC_LEN=1024; the pass is
            // finishing at that point so the wrapped value is never presented.
            if (w_out_hs) begin
                r_cnt <= r_cnt + 10'd1;
            end
        end
    end

`ifdef S_MAQ_SEQ_SATCNT_EN
    logic [10:0] r_sat_cnt;
    logic        w_sat_hit;

    assign w_sat_hit = (S_sat_MAQ == 8'd0) || (S_sat_MAQ == 8'd255);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sat_cnt <= 11'd0;
        end else if ((r_state == c_ST_IDLE) && start) begin
            r_sat_cnt <= 11'd0;
        end else if ((r_state == c_ST_MAQ) && w_sat_hit) begin
            r_sat_cnt <= r_sat_cnt + 11'd1;
        end
    end

    assign sat_cnt = r_sat_cnt;
`endif

    assign busy      = r_busy;
    assign done      = r_done;
    assign in_ready  = r_in_ready;
    assign out_valid = r_out_valid;
    assign comb_ctrl = r_comb_ctrl;
    assign temp_regA = r_temp_a;
    assign temp_regB = r_temp_b;
    assign temp_regC = r_temp_c;
    assign out_c     = r_out_c;
    assign out_idx   = r_cnt;

endmodule
`default_nettype wire
